// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-PC sequencer: NPC control codes,
// fetch FSM state encodings and the architectural reset vector.
package pc_sequencer_pkg;

   // NPC control codes carried by the instruction in D
   localparam logic [3:0] NPC_NONE = 4'd0;
   localparam logic [3:0] NPC_beq  = 4'd1;
   localparam logic [3:0] NPC_bne  = 4'd2;
   localparam logic [3:0] NPC_blez = 4'd3;
   localparam logic [3:0] NPC_bgtz = 4'd4;
   localparam logic [3:0] NPC_bltz = 4'd5;
   localparam logic [3:0] NPC_bgez = 4'd6;
   localparam logic [3:0] NPC_j    = 4'd7;
   localparam logic [3:0] NPC_jal  = 4'd8;
   localparam logic [3:0] NPC_jr   = 4'd9;

   // Fetch FSM states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   // PC loaded on reset
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_sequencer_sel_mux.sv
// Next-PC priority selector: redirect beats branch/jump target beats PC+4.
module pc_sel_mux (
   input  logic        redir_valid_i,
   input  logic [31:0] redir_pc_i,
   input  logic [3:0]  branch_i,
   input  logic [31:0] next_pc_i,
   input  logic [31:0] pc4_i,
   output logic [31:0] sel_o
);
   import pc_sequencer_pkg::*;

   // Fixed priority; targets pass through unaligned so the exception logic sees them
   always_comb begin
      sel_o = pc4_i;
      if (redir_valid_i)
         sel_o = redir_pc_i;
      else if (branch_i != NPC_NONE)
         sel_o = next_pc_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner and instruction-fetch sequencer. Issues one
// req/ack fetch per instruction, presents the result to the F/D register
// and steps the PC once D accepts it (or on an exception/eret redirect).
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = pc_sequencer_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_stall,
   input  logic [3:0]  i_branch,
   input  logic [31:0] i_nextPC,
   input  logic        i_redir_valid,
   input  logic [31:0] i_redir_pc,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_PC_F,
   output logic [31:0] o_PC4_F,
   output logic [31:0] o_instr_F,
   output logic        o_valid_F
);
   import pc_sequencer_pkg::*;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] pc4;
   logic [31:0] sel_pc;

   assign pc4 = pc_q + 32'd4;

   pc_sel_mux u_sel (
      .redir_valid_i (i_redir_valid),
      .redir_pc_i    (i_redir_pc),
      .branch_i      (i_branch),
      .next_pc_i     (i_nextPC),
      .pc4_i         (pc4),
      .sel_o         (sel_pc)
   );

   // Fetch FSM next-state: the request address stays at pc_q until ack, so
   // redirects seen mid-fetch are parked and applied when the ack arrives
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (i_redir_valid) pc_d = i_redir_pc;
         end
         S_REQ: begin
            valid_d = 1'b0;
            if (i_redir_valid) begin
               pend_valid_d = 1'b1;
               pend_pc_d    = i_redir_pc;
            end
            if (i_imem_ack) begin
               if (pend_valid_q || i_redir_valid) begin
                  // wrong-path data: drop it and refetch from the redirect target
                  pc_d         = i_redir_valid ? i_redir_pc : pend_pc_q;
                  pend_valid_d = 1'b0;
               end else begin
                  instr_d = i_imem_rdata;
                  valid_d = 1'b1;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // redirect flushes the held instruction even under stall
            if (i_redir_valid || !i_stall) begin
               pc_d    = sel_pc;
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= 32'd0;
         valid_q      <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   assign o_imem_req  = (state_q == S_REQ);
   assign o_imem_addr = pc_q;
   assign o_PC_F      = pc_q;
   assign o_PC4_F     = pc4;
   assign o_instr_F   = instr_q;
   assign o_valid_F   = valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_stall;
   logic [3:0]  i_branch;
   logic [31:0] i_nextPC;
   logic        i_redir_valid;
   logic [31:0] i_redir_pc;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic [31:0] o_PC_F;
   logic [31:0] o_PC4_F;
   logic [31:0] o_instr_F;
   logic        o_valid_F;

   int checks = 0;
   int errors = 0;

   // behavioural model: what F is doing, in plain words
   bit          m_idle, m_fetching, m_holding;
   logic [31:0] m_pc, m_instr;
   bit          m_valid;
   logic [31:0] m_pend[$];

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .i_stall       (i_stall),
      .i_branch      (i_branch),
      .i_nextPC      (i_nextPC),
      .i_redir_valid (i_redir_valid),
      .i_redir_pc    (i_redir_pc),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rdata  (i_imem_rdata),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .o_PC_F        (o_PC_F),
      .o_PC4_F       (o_PC4_F),
      .o_instr_F     (o_instr_F),
      .o_valid_F     (o_valid_F)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // advance the model by one clock with the given inputs
   task automatic model_step(input bit rst, input bit ack, input logic [31:0] rdata,
                             input bit stall, input logic [3:0] br, input logic [31:0] npc,
                             input bit rv, input logic [31:0] rpc);
      if (!rst) begin
         m_idle = 1; m_fetching = 0; m_holding = 0;
         m_pc = 32'h0000_3000; m_instr = 0; m_valid = 0;
         m_pend.delete();
      end else if (m_idle) begin
         m_idle = 0; m_fetching = 1;
         if (rv) m_pc = rpc;
      end else if (m_fetching) begin
         if (rv) begin m_pend.delete(); m_pend.push_back(rpc); end
         if (ack) begin
            if (m_pend.size() != 0) m_pc = m_pend.pop_front();
            else begin
               m_instr = rdata; m_valid = 1;
               m_fetching = 0; m_holding = 1;
            end
         end
      end else if (m_holding) begin
         if (rv || !stall) begin
            if (rv) m_pc = rpc;
            else if (br != 4'd0) m_pc = npc;
            else m_pc = m_pc + 32'd4;
            m_valid = 0; m_holding = 0; m_fetching = 1;
         end
      end
   endtask

   // drive one cycle of inputs, step the model, then compare at the next negedge
   task automatic cyc(input bit rst, input bit ack, input logic [31:0] rdata,
                      input bit stall, input logic [3:0] br, input logic [31:0] npc,
                      input bit rv, input logic [31:0] rpc);
      reset = rst; i_imem_ack = ack; i_imem_rdata = rdata; i_stall = stall;
      i_branch = br; i_nextPC = npc; i_redir_valid = rv; i_redir_pc = rpc;
      model_step(rst, ack, rdata, stall, br, npc, rv, rpc);
      @(negedge clk);
      chk("req",   {31'd0, o_imem_req}, {31'd0, m_fetching});
      chk("addr",  o_imem_addr, m_pc);
      chk("pc",    o_PC_F, m_pc);
      chk("pc4",   o_PC4_F, m_pc + 32'd4);
      chk("valid", {31'd0, o_valid_F}, {31'd0, m_valid});
      chk("instr", o_instr_F, m_instr);
   endtask

   task automatic idle_cyc(input bit ack);
      cyc(1, ack, $urandom, 0, 4'd0, 32'd0, 0, 32'd0);
   endtask

   // run with ack until F holds an instruction (bounded)
   task automatic reach_hold();
      for (int k = 0; k < 8 && !m_holding; k++) idle_cyc(1);
      chk("reach_hold", {31'd0, m_holding}, 32'd1);
   endtask

   initial begin
      reset = 0; i_stall = 0; i_branch = 0; i_nextPC = 0; i_redir_valid = 0;
      i_redir_pc = 0; i_imem_ack = 0; i_imem_rdata = 0;
      @(negedge clk);
      // reset state
      cyc(0, 0, 0, 0, 4'd0, 0, 0, 0);
      cyc(0, 1, 32'h1111_1111, 0, 4'd0, 0, 0, 0);
      chk("rst_pc", o_PC_F, 32'h0000_3000);
      chk("rst_valid", {31'd0, o_valid_F}, 32'd0);

      // 1: zero-wait streaming
      for (int k = 0; k < 7; k++) idle_cyc(1);
      chk("stream_addr", o_imem_addr, 32'h0000_300C);

      // 2: delayed ack
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 4'd0, 0, 0, 0);
      cyc(1, 1, 32'hCAFE_0001, 0, 4'd0, 0, 0, 0);
      chk("late_instr", o_instr_F, 32'hCAFE_0001);

      // 3: stall in S_HOLD with branch pending in D
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 4'd1, 32'h0000_3040, 0, 0);
      cyc(1, 0, 0, 0, 4'd1, 32'h0000_3040, 0, 0);
      chk("br_addr", o_imem_addr, 32'h0000_3040);

      // 4: redirect during an outstanding fetch
      cyc(1, 0, 0, 0, 4'd0, 0, 1, 32'h0000_4180);
      cyc(1, 0, 0, 0, 4'd0, 0, 0, 0);
      cyc(1, 1, 32'hDEAD_BEEF, 0, 4'd0, 0, 0, 0);
      chk("redir_req_addr", o_imem_addr, 32'h0000_4180);
      chk("redir_req_valid", {31'd0, o_valid_F}, 32'd0);

      // 5: redirect in S_HOLD overrides stall
      reach_hold();
      cyc(1, 0, 0, 1, 4'd0, 0, 1, 32'h0000_4180);
      chk("hold_redir_addr", o_imem_addr, 32'h0000_4180);

      // 6: reset while a fetch is outstanding, ack coincident
      cyc(0, 1, 32'h5555_AAAA, 0, 4'd0, 0, 0, 0);
      cyc(1, 1, 32'h6666_7777, 0, 4'd0, 0, 0, 0);

      // PC+4 wraps modulo 2^32
      reach_hold();
      cyc(1, 0, 0, 0, 4'd0, 0, 1, 32'hFFFF_FFFC);
      reach_hold();
      idle_cyc(0);
      chk("wrap_addr", o_imem_addr, 32'h0000_0000);

      // random traffic, including misaligned targets
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(99) >= 2), ($urandom_range(99) < 60), $urandom,
             ($urandom_range(99) < 40),
             ($urandom_range(99) < 30) ? 4'($urandom_range(9, 1)) : 4'd0, $urandom,
             ($urandom_range(99) < 10), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
